// File: rtl/codebook_b0_ctrl_if.sv
// Bus bundle between the codebook-0 sequencer, its combinational lookup and the bit packer.
//   symbol in   : sym_valid_i, sym_data_i, sym_ready_o
//   flush       : flush_i (level request), flush_done_o (one-cycle pulse)
//   lookup      : ap_cnt_o, ap_data_o out to codebook_b0_f; encode_match_i/length_i/data_i back
//   codeword    : code_valid_o, code_ready_i, code_data_o, code_length_o
//   status      : overflow_o (one-cycle pulse, prefix dropped)
// Signal names keep the controller's point of view; the master modport is the controller,
// the slave modport is its environment (symbol source, lookup, packer).
interface codebook_b0_ctrl_if #(
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int SYM_WIDTH           = 4
);
    logic                           sym_valid_i;
    logic [SYM_WIDTH-1:0]           sym_data_i;
    logic                           sym_ready_o;
    logic                           flush_i;
    logic                           flush_done_o;
    logic [5:0]                     ap_cnt_o;
    logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o;
    logic                           encode_match_i;
    logic [5:0]                     encode_length_i;
    logic [ENCODE_DATALENGTH-1:0]   encode_data_i;
    logic                           code_valid_o;
    logic                           code_ready_i;
    logic [ENCODE_DATALENGTH-1:0]   code_data_o;
    logic [5:0]                     code_length_o;
    logic                           overflow_o;

    modport master (
        input  sym_valid_i, sym_data_i, flush_i,
        input  encode_match_i, encode_length_i, encode_data_i, code_ready_i,
        output sym_ready_o, flush_done_o, ap_cnt_o, ap_data_o,
        output code_valid_o, code_data_o, code_length_o, overflow_o
    );

    modport slave (
        output sym_valid_i, sym_data_i, flush_i,
        output encode_match_i, encode_length_i, encode_data_i, code_ready_i,
        input  sym_ready_o, flush_done_o, ap_cnt_o, ap_data_o,
        input  code_valid_o, code_data_o, code_length_o, overflow_o
    );
endinterface

// File: rtl/codebook_b0_ctrl.sv
// Sequencer for the low-entropy codebook-0 lookup of the hybrid entropy coder.
// Shifts 4-bit symbols into an active prefix (newest symbol in bits [3:0]), presents it to the
// combinational lookup, and on a match registers the codeword and offers it to the bit packer
// over valid/ready. Flush terminates a residual prefix by appending 4'hF symbols; a prefix
// that reaches CNT_MAX symbols without a match is dropped with an overflow pulse.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   bus      codebook_b0_ctrl_if.master (symbol in, flush, lookup, codeword out, overflow)
module codebook_b0_ctrl #(
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int SYM_WIDTH           = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    codebook_b0_ctrl_if.master bus
);
    localparam int         CNT_MAX   = CODEBOOK_LENGTH_MAX / SYM_WIDTH;
    localparam logic [5:0] CNT_MAX_C = 6'(CNT_MAX);
    localparam logic [SYM_WIDTH-1:0] FLUSH_SYM = '1;

    typedef enum logic [1:0] {IDLE, LOOKUP, EMIT} state_t;

    state_t                         state_reg, state_next;
    logic [5:0]                     ap_cnt_reg, ap_cnt_next;
    logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_reg, ap_data_next;
    logic [ENCODE_DATALENGTH-1:0]   code_data_reg, code_data_next;
    logic [5:0]                     code_length_reg, code_length_next;
    logic                           flush_pending_reg, flush_pending_next;
    logic                           flush_done_reg, flush_done_next;
    logic                           overflow_reg, overflow_next;
    logic                           flush_req;

    // The cycle flush_done_o is high the requester is still allowed to hold flush_i;
    // ignoring it then keeps one request from producing a second completion pulse.
    assign flush_req = bus.flush_i && !flush_done_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg         <= IDLE;
            ap_cnt_reg        <= '0;
            ap_data_reg       <= '0;
            code_data_reg     <= '0;
            code_length_reg   <= '0;
            flush_pending_reg <= 1'b0;
            flush_done_reg    <= 1'b0;
            overflow_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            ap_cnt_reg        <= ap_cnt_next;
            ap_data_reg       <= ap_data_next;
            code_data_reg     <= code_data_next;
            code_length_reg   <= code_length_next;
            flush_pending_reg <= flush_pending_next;
            flush_done_reg    <= flush_done_next;
            overflow_reg      <= overflow_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        ap_cnt_next        = ap_cnt_reg;
        ap_data_next       = ap_data_reg;
        code_data_next     = code_data_reg;
        code_length_next   = code_length_reg;
        flush_pending_next = flush_pending_reg;
        flush_done_next    = 1'b0;
        overflow_next      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // A real symbol wins over a flush request in the same cycle.
                if (bus.sym_valid_i) begin
                    ap_data_next = {ap_data_reg[CODEBOOK_LENGTH_MAX-SYM_WIDTH-1:0], bus.sym_data_i};
                    ap_cnt_next  = ap_cnt_reg + 6'd1;
                    state_next   = LOOKUP;
                end else if (flush_req && ap_cnt_reg != 6'd0) begin
                    ap_data_next       = {ap_data_reg[CODEBOOK_LENGTH_MAX-SYM_WIDTH-1:0], FLUSH_SYM};
                    ap_cnt_next        = ap_cnt_reg + 6'd1;
                    flush_pending_next = 1'b1;
                    state_next         = LOOKUP;
                end else if (flush_req) begin
                    flush_done_next = 1'b1;
                end
            end
            LOOKUP: begin
                if (bus.encode_match_i) begin
                    code_data_next   = bus.encode_data_i;
                    code_length_next = bus.encode_length_i;
                    ap_cnt_next      = '0;
                    ap_data_next     = '0;
                    state_next       = EMIT;
                end else if (ap_cnt_reg == CNT_MAX_C) begin
                    // Prefix full with no codeword: drop it. A flush in progress ends here too.
                    overflow_next      = 1'b1;
                    flush_done_next    = flush_pending_reg;
                    flush_pending_next = 1'b0;
                    ap_cnt_next        = '0;
                    ap_data_next       = '0;
                    state_next         = IDLE;
                end else begin
                    state_next = IDLE;
                end
            end
            EMIT: begin
                if (bus.code_ready_i) begin
                    flush_done_next    = flush_pending_reg;
                    flush_pending_next = 1'b0;
                    state_next         = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is forced low while reset is asserted even though the state already reads IDLE.
    assign bus.sym_ready_o   = rst_n_i && (state_reg == IDLE);
    assign bus.code_valid_o  = (state_reg == EMIT);
    assign bus.ap_cnt_o      = ap_cnt_reg;
    assign bus.ap_data_o     = ap_data_reg;
    assign bus.code_data_o   = code_data_reg;
    assign bus.code_length_o = code_length_reg;
    assign bus.flush_done_o  = flush_done_reg;
    assign bus.overflow_o    = overflow_reg;
endmodule

// File: tb/tb_codebook_b0_ctrl.sv
// Testbench for codebook_b0_ctrl: small codebook-0 lookup model, codeword scoreboard,
// pulse counters and directed scenarios (single symbol, multi-symbol, back-pressure,
// overflow, flush with and without prefix, asynchronous reset during EMIT).
module tb_codebook_b0_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    codebook_b0_ctrl_if bus ();

    codebook_b0_ctrl dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int fd_cnt   = 0;
    int ovf_cnt  = 0;
    logic [26:0] exp_q[$];   // {length, data}

    // Combinational lookup model: the few prefixes these scenarios need.
    always_comb begin
        bus.encode_match_i  = 1'b0;
        bus.encode_length_i = 6'd0;
        bus.encode_data_i   = 21'd0;
        if (bus.ap_cnt_o == 6'd1 && bus.ap_data_o == 64'hF) begin
            bus.encode_match_i = 1'b1; bus.encode_length_i = 6'd5;  bus.encode_data_i = 21'b10010;
        end else if (bus.ap_cnt_o == 6'd3 && bus.ap_data_o == 64'h44F) begin
            bus.encode_match_i = 1'b1; bus.encode_length_i = 6'd12; bus.encode_data_i = 21'b111111111110;
        end else if (bus.ap_cnt_o == 6'd2 && bus.ap_data_o == 64'h0F) begin
            bus.encode_match_i = 1'b1; bus.encode_length_i = 6'd8;  bus.encode_data_i = 21'b11011110;
        end else if (bus.ap_cnt_o == 6'd2 && bus.ap_data_o == 64'h7F) begin
            bus.encode_match_i = 1'b1; bus.encode_length_i = 6'd10; bus.encode_data_i = 21'b1111101100;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples 1ns after the falling edge, when both DUT outputs and bench inputs are settled.
    logic        prev_stall = 1'b0;
    logic [20:0] prev_data;
    logic [5:0]  prev_len;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.flush_done_o) fd_cnt++;
            if (bus.overflow_o) ovf_cnt++;
            if (prev_stall && bus.code_valid_o) begin
                check("hold_data", 64'(bus.code_data_o), 64'(prev_data));
                check("hold_len", 64'(bus.code_length_o), 64'(prev_len));
            end
            if (bus.code_valid_o && bus.code_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_code", 64'(bus.code_valid_o), 64'd0);
                end else begin
                    logic [26:0] e;
                    e = exp_q.pop_front();
                    check("code_data", 64'(bus.code_data_o), 64'(e[20:0]));
                    check("code_len", 64'(bus.code_length_o), 64'(e[26:21]));
                    $display("code handshake: data 'b%0b len %0d", bus.code_data_o, bus.code_length_o);
                end
            end
            prev_stall = bus.code_valid_o && !bus.code_ready_i;
            prev_data  = bus.code_data_o;
            prev_len   = bus.code_length_o;
        end
    end

    // Called at a falling edge with sym_valid_i already high.
    task automatic wait_accept();
        int n = 0;
        while (!bus.sym_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.sym_valid_i = 1'b0;
    endtask

    task automatic send_sym(input logic [3:0] s);
        bus.sym_valid_i = 1'b1;
        bus.sym_data_i  = s;
        wait_accept();
        $display("symbol %0h accepted", s);
    endtask

    task automatic push_code(input logic [20:0] d, input logic [5:0] l);
        exp_q.push_back({l, d});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int fd0, ovf0, n;
        bus.sym_valid_i  = 1'b0;
        bus.sym_data_i   = 4'h0;
        bus.flush_i      = 1'b0;
        bus.code_ready_i = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_sym_ready", 64'(bus.sym_ready_o), 64'd0);
        check("rst_code_valid", 64'(bus.code_valid_o), 64'd0);
        check("rst_ap_cnt", 64'(bus.ap_cnt_o), 64'd0);
        check("rst_ap_data", bus.ap_data_o, 64'd0);
        check("rst_code_data", 64'(bus.code_data_o), 64'd0);
        check("rst_code_len", 64'(bus.code_length_o), 64'd0);
        check("rst_flush_done", 64'(bus.flush_done_o), 64'd0);
        check("rst_overflow", 64'(bus.overflow_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_sym_ready", 64'(bus.sym_ready_o), 64'd1);

        // 1: single F symbol
        push_code(21'b10010, 6'd5);
        send_sym(4'hF);
        check("t1_lookup_cnt", 64'(bus.ap_cnt_o), 64'd1);
        check("t1_lookup_data", bus.ap_data_o, 64'hF);
        check("t1_lookup_ready", 64'(bus.sym_ready_o), 64'd0);
        @(negedge clk);
        check("t1_emit_valid", 64'(bus.code_valid_o), 64'd1);
        check("t1_emit_cnt", 64'(bus.ap_cnt_o), 64'd0);
        drain();

        // 2: 4,4 builds prefix, F completes the codeword
        send_sym(4'h4);
        send_sym(4'h4);
        repeat (3) @(negedge clk);
        check("t2_data_44", bus.ap_data_o, 64'h44);
        check("t2_cnt_2", 64'(bus.ap_cnt_o), 64'd2);
        check("t2_no_code", 64'(bus.code_valid_o), 64'd0);
        push_code(21'b111111111110, 6'd12);
        send_sym(4'hF);
        drain();
        check("t2_cnt_clear", 64'(bus.ap_cnt_o), 64'd0);

        // 3: back-pressure with a symbol offered during EMIT
        bus.code_ready_i = 1'b0;
        push_code(21'b11011110, 6'd8);
        send_sym(4'h0);
        send_sym(4'hF);
        n = 0;
        while (!bus.code_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_valid_timeout", 64'(n < 20), 64'd1);
        bus.sym_valid_i = 1'b1;
        bus.sym_data_i  = 4'hF;
        push_code(21'b10010, 6'd5);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_ready", 64'(bus.sym_ready_o), 64'd0);
            check("t3_stall_valid", 64'(bus.code_valid_o), 64'd1);
            check("t3_stall_data", 64'(bus.code_data_o), 64'(21'b11011110));
            @(negedge clk);
        end
        bus.code_ready_i = 1'b1;
        wait_accept();
        drain();

        // 4: sixteen 1-symbols overflow the prefix
        ovf0 = ovf_cnt;
        for (int i = 0; i < 15; i++) send_sym(4'h1);
        @(negedge clk);
        check("t4_cnt_15", 64'(bus.ap_cnt_o), 64'd15);
        check("t4_data_15", bus.ap_data_o, 64'h111111111111111);
        send_sym(4'h1);
        repeat (3) @(negedge clk);
        check("t4_overflow_pulses", 64'(ovf_cnt - ovf0), 64'd1);
        check("t4_cnt_clear", 64'(bus.ap_cnt_o), 64'd0);
        check("t4_data_clear", bus.ap_data_o, 64'd0);
        check("t4_no_code", 64'(exp_q.size()), 64'd0);

        // 5: flush with residual prefix, then flush with empty prefix
        fd0 = fd_cnt;
        push_code(21'b1111101100, 6'd10);
        send_sym(4'h7);
        bus.flush_i = 1'b1;
        n = 0;
        while (!bus.flush_done_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        bus.flush_i = 1'b0;
        check("t5_flush_timeout", 64'(n < 30), 64'd1);
        drain();
        check("t5_flush_pulses", 64'(fd_cnt - fd0), 64'd1);
        check("t5_cnt_clear", 64'(bus.ap_cnt_o), 64'd0);
        fd0 = fd_cnt;
        bus.flush_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.flush_done_o && n < 10);
        bus.flush_i = 1'b0;
        check("t5_empty_latency", 64'(n), 64'd1);
        repeat (3) @(negedge clk);
        check("t5_empty_pulses", 64'(fd_cnt - fd0), 64'd1);
        check("t5_empty_no_code", 64'(bus.code_valid_o), 64'd0);
        $display("flush scenarios done");

        // 6: asynchronous reset while a codeword is held in EMIT
        bus.code_ready_i = 1'b0;
        send_sym(4'hF);
        @(negedge clk);
        check("t6_emit_valid", 64'(bus.code_valid_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(bus.code_valid_o), 64'd0);
        check("t6_async_cnt", 64'(bus.ap_cnt_o), 64'd0);
        check("t6_async_data", bus.ap_data_o, 64'd0);
        check("t6_async_code", 64'(bus.code_data_o), 64'd0);
        check("t6_async_ready", 64'(bus.sym_ready_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.code_ready_i = 1'b1;
        @(negedge clk);
        push_code(21'b10010, 6'd5);
        send_sym(4'hF);
        check("t6_lookup_cnt", 64'(bus.ap_cnt_o), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
